masked_hpc2_mul_pipe: RTL and testbench
=======================================

Name: masked_hpc2_mul_pipe

Overview:
Multi-lane, flow-controlled masked HPC2 GF(2^BIT_WIDTH) multiplier for the S-box datapath.
- NUM_LANES independent d-share multiplications share one valid/ready handshake and a two-stage pipeline.
- A and B operands arrive in the same cycle; the block aligns A internally.
- Each pipeline register is clock-enabled only when it loads valid data, so bubbles and stalls cause no share transitions.
- Intended to replace hand-scheduled multiplier instances where the surrounding pipeline stalls, e.g. while waiting on the randomness source.

Parameters:
- NUM_SHARES, 2, number of Boolean shares d (>= 2)
- BIT_WIDTH, 2, field element width; product computed by generic_mul (BIT_WIDTH=1 means AND)
- NUM_LANES, 1, independent multiplications per transaction
- NUM_QUAD (localparam), num_quad(NUM_SHARES), random elements per lane

Ports:
- in_clock  input  1  single clock, rising edge
- in_reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept a transaction this cycle
- in_a  input  NUM_LANES*NUM_SHARES*BIT_WIDTH  shared A operand, per lane
- in_b  input  NUM_LANES*NUM_SHARES*BIT_WIDTH  shared B operand, per lane
- in_r  input  NUM_LANES*NUM_QUAD*BIT_WIDTH  fresh randomness, per lane
- in_r_valid  input  1  randomness valid
- out_r_take  output  1  randomness consumed this cycle (== accept)
- out_valid  output  1  out_c holds a valid result
- out_ready  input  1  downstream accepts
- out_c  output  NUM_LANES*NUM_SHARES*BIT_WIDTH  shared product

Behaviour:
- Reset, async: all stage registers and valid flags clear to 0. out_valid=0, out_c=0. in_ready=1 one cycle after reset deasserts, and combinationally while in_reset is low.
- accept = in_valid & in_r_valid & in_ready. out_r_take = accept.
- Stall logic: adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1.
  - in_ready must not depend on in_valid or in_r_valid.
- Stage 1 loads on accept, per lane, i != j, jj as in the HPC2 layout:
  - a1 = a, b1 = b, r1 = r.
  - vb1[i][jj] = b[j] ^ r[qindex(i,j)].
  - v1 <= accept when adv1 is true; otherwise v1 holds.
- Stage 2 loads on v1 & adv2:
  - m2[i][j] = a1[i] * vb1[i][jj] for i != j.
  - m2[i][i] = a1[i] * b1[i].
  - w2[i][jj] = ~a1[i] * r1[qindex(i,j)].
  - v2 <= v1 when adv2 is true.
- Output is combinational from stage-2 registers only: out_c[l][i] = XOR of m2[l][i][*] and w2[l][i][*], i.e. 2*NUM_SHARES-1 terms.
- Latency: exactly 2 cycles accept -> out_valid with no backpressure. Throughput: 1 transaction per cycle.
- Backpressure:
  - While out_valid & !out_ready, out_c is stable and m2/w2 hold.
  - With both stages full, in_ready=0.
- Bubble (adv true, no valid data): the target register holds its old value. No zero-fill and no reload.
- in_valid without in_r_valid: no accept, no randomness consumed, registers hold.
- Simultaneous pop and push when full: allowed. in_ready=1 when out_ready=1 and v2=1.
- Reset mid-transaction: in-flight results are discarded and out_valid drops asynchronously. No partial output.
- Correctness: XOR over shares of out_c equals (XOR of a shares) * (XOR of b shares) in GF(2^BIT_WIDTH), for every lane.
- Security: per lane and per pair (i,j), b[j] is never combined with a[i] before the stage-1 register. Randomness is used exactly once per transaction.

Decomposition:
- Shared package (aes128_package): num_quad(), qindex(); add typedef for the per-lane share vector and localparam MUL_PIPE_LATENCY = 2.
- Sub-module masked_hpc2_lane: one lane's stage-1/stage-2 datapath with two enable inputs (en1, en2). It reuses generic_mul and reduce_xor.
- Top level owns the valid flags and handshake and instantiates NUM_LANES lanes.

Test Plan:
- Basic, BIT_WIDTH=1, d=2, 1 lane: a shares (1,0), b shares (0,1), r=1, held out_ready=1 -> out_valid 2 cycles after accept; out_c[0]^out_c[1]=1. Repeat with a shares (1,1) -> unmasked 0.
- Streaming, d=3, 4 lanes, BIT_WIDTH=2: 100 back-to-back random transactions -> one result per cycle, in order. Each lane's unmasked result equals the generic_mul reference.
- Backpressure: out_ready=0 for 5 cycles after 3 accepts -> 2 accepted then in_ready=0; out_c stable; stage regs hold. Release -> remaining results delivered in order, none lost or duplicated.
- Randomness starvation: in_valid=1, in_r_valid=0 for 4 cycles -> out_r_take=0, no accept, register values unchanged. Raise in_r_valid -> accept in the same cycle.
- Bubble hold: accept one transaction, idle 10 cycles -> stage-1/2 register contents never change after the result is output.
- Async reset with both stages full -> out_valid and out_c go to 0 without a clock edge. After release, first accept yields a correct result at +2 cycles.

Source files
------------

// File: rtl/masked_hpc2_mul_pipe_pkg.sv
// Shared helpers for the masked HPC2 multiplier: share/randomness indexing and GF(2^n) multiply.
// Field widths up to MAX_FIELD_WIDTH are supported by generic_mul.
package masked_hpc2_mul_pipe_pkg;

    localparam int MUL_PIPE_LATENCY = 2;
    localparam int MAX_FIELD_WIDTH  = 8;

    typedef logic [MAX_FIELD_WIDTH-1:0] gf_word_t;
    typedef logic [MAX_FIELD_WIDTH:0]   gf_poly_t;

    // One fresh random element per unordered share pair (i,j).
    function automatic int num_quad(input int d);
        return (d * (d - 1)) / 2;
    endfunction

    function automatic int qindex(input int i, input int j, input int d);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    // Maps slot s (0..d-2) of share i onto the partner share index j != i.
    function automatic int other_share(input int i, input int slot);
        return (slot < i) ? slot : slot + 1;
    endfunction

    function automatic gf_poly_t field_poly(input int width);
        case (width)
            1:       return 9'h003;
            2:       return 9'h007;
            3:       return 9'h00B;
            4:       return 9'h013;
            5:       return 9'h025;
            6:       return 9'h043;
            7:       return 9'h083;
            default: return 9'h11B;
        endcase
    endfunction

    // Shift-and-add multiply with reduction each step; width 1 degenerates to AND.
    function automatic gf_word_t generic_mul(input gf_word_t x, input gf_word_t y, input int width);
        gf_poly_t shifted;
        gf_poly_t poly;
        gf_word_t acc;
        poly    = field_poly(width);
        shifted = {1'b0, x};
        acc     = '0;
        for (int k = 0; k < MAX_FIELD_WIDTH; k++) begin
            if (k < width) begin
                if (y[k]) begin
                    acc = acc ^ shifted[MAX_FIELD_WIDTH-1:0];
                end
                shifted = shifted << 1;
                if ((shifted >> width) != '0) begin
                    shifted = shifted ^ poly;
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/masked_hpc2_lane.sv
// One lane of the HPC2 multiplier: stage-1 operand/refresh registers and stage-2 partial products.
// Each register bank only toggles when its enable is asserted, so idle cycles leak no share transitions.
module masked_hpc2_lane
    import masked_hpc2_mul_pipe_pkg::*;
#(
    parameter int  NUM_SHARES = 2,
    parameter int  BIT_WIDTH  = 2,
    localparam int NUM_QUAD   = num_quad(NUM_SHARES)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            en1,
    input  logic                            en2,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0] a,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0] b,
    input  logic [NUM_QUAD*BIT_WIDTH-1:0]   r,
    output logic [NUM_SHARES*BIT_WIDTH-1:0] c
);

    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] a_sh;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] b_sh;
    logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]   r_sh;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] a1;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] b1;
    logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]   r1;
    logic [NUM_SHARES-1:0][NUM_SHARES-2:0][BIT_WIDTH-1:0] vb_next;
    logic [NUM_SHARES-1:0][NUM_SHARES-2:0][BIT_WIDTH-1:0] vb1;
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] m_next;
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] m2;
    logic [NUM_SHARES-1:0][NUM_SHARES-2:0][BIT_WIDTH-1:0] w_next;
    logic [NUM_SHARES-1:0][NUM_SHARES-2:0][BIT_WIDTH-1:0] w2;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] c_sh;

    assign a_sh = a;
    assign b_sh = b;
    assign r_sh = r;
    assign c    = c_sh;

    // Cross-domain B shares are only refreshed here; they meet A after the stage-1 register.
    always_comb begin
        vb_next = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int s = 0; s < NUM_SHARES - 1; s++) begin
                vb_next[i][s] = b_sh[other_share(i, s)]
                              ^ r_sh[qindex(i, other_share(i, s), NUM_SHARES)];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a1  <= '0;
            b1  <= '0;
            r1  <= '0;
            vb1 <= '0;
        end else if (en1) begin
            a1  <= a_sh;
            b1  <= b_sh;
            r1  <= r_sh;
            vb1 <= vb_next;
        end
    end

    // The ~a*r terms cancel pairwise with the r refresh folded into vb1 once shares are summed.
    always_comb begin
        gf_word_t                 prod;
        logic [BIT_WIDTH-1:0]     a_inv;
        m_next = '0;
        w_next = '0;
        prod   = '0;
        a_inv  = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            prod         = generic_mul(gf_word_t'(a1[i]), gf_word_t'(b1[i]), BIT_WIDTH);
            m_next[i][i] = prod[BIT_WIDTH-1:0];
            a_inv        = ~a1[i];
            for (int s = 0; s < NUM_SHARES - 1; s++) begin
                prod = generic_mul(gf_word_t'(a1[i]), gf_word_t'(vb1[i][s]), BIT_WIDTH);
                m_next[i][other_share(i, s)] = prod[BIT_WIDTH-1:0];
                prod = generic_mul(gf_word_t'(a_inv),
                                   gf_word_t'(r1[qindex(i, other_share(i, s), NUM_SHARES)]),
                                   BIT_WIDTH);
                w_next[i][s] = prod[BIT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m2 <= '0;
            w2 <= '0;
        end else if (en2) begin
            m2 <= m_next;
            w2 <= w_next;
        end
    end

    // Output compression reads registered partial products only, so no glitchy recombination.
    always_comb begin
        c_sh = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int j = 0; j < NUM_SHARES; j++) begin
                c_sh[i] = c_sh[i] ^ m2[i][j];
            end
            for (int s = 0; s < NUM_SHARES - 1; s++) begin
                c_sh[i] = c_sh[i] ^ w2[i][s];
            end
        end
    end

endmodule

// File: rtl/masked_hpc2_mul_pipe.sv
// Flow-controlled multi-lane masked HPC2 multiplier: a two-stage pipeline behind one valid/ready pair.
// The top owns the stage valid flags and the handshake; lanes only see clock enables.
module masked_hpc2_mul_pipe
    import masked_hpc2_mul_pipe_pkg::*;
#(
    parameter int  NUM_SHARES = 2,
    parameter int  BIT_WIDTH  = 2,
    parameter int  NUM_LANES  = 1,
    localparam int NUM_QUAD   = num_quad(NUM_SHARES)
) (
    input  logic                                      in_clock,
    input  logic                                      in_reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0] in_a,
    input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0] in_b,
    input  logic [NUM_LANES*NUM_QUAD*BIT_WIDTH-1:0]   in_r,
    input  logic                                      in_r_valid,
    output logic                                      out_r_take,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0] out_c
);

    localparam int LANE_W = NUM_SHARES * BIT_WIDTH;
    localparam int RAND_W = NUM_QUAD * BIT_WIDTH;

    logic v1;
    logic v2;
    logic adv1;
    logic adv2;
    logic accept;
    logic load2;

    // Ready is a function of pipeline occupancy only, never of the incoming valids.
    assign adv2       = ~v2 | out_ready;
    assign adv1       = ~v1 | adv2;
    assign in_ready   = adv1 & ~in_reset;
    assign accept     = in_valid & in_r_valid & in_ready;
    assign load2      = v1 & adv2;
    assign out_r_take = accept;
    assign out_valid  = v2;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (adv2) begin
                v2 <= v1;
            end
            if (adv1) begin
                v1 <= accept;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        masked_hpc2_lane #(
            .NUM_SHARES (NUM_SHARES),
            .BIT_WIDTH  (BIT_WIDTH)
        ) u_lane (
            .clock (in_clock),
            .reset (in_reset),
            .en1   (accept),
            .en2   (load2),
            .a     (in_a[l*LANE_W +: LANE_W]),
            .b     (in_b[l*LANE_W +: LANE_W]),
            .r     (in_r[l*RAND_W +: RAND_W]),
            .c     (out_c[l*LANE_W +: LANE_W])
        );
    end

endmodule

// File: tb/tb_masked_hpc2_mul_pipe.sv
// Scoreboard bench for masked_hpc2_mul_pipe (3 shares, GF(4), 4 lanes) driven by directed steps.
module tb_masked_hpc2_mul_pipe;
    import masked_hpc2_mul_pipe_pkg::*;

    localparam int D  = 3;
    localparam int BW = 2;
    localparam int L  = 4;
    localparam int Q  = (D * (D - 1)) / 2;
    localparam int SW = L * D * BW;
    localparam int RW = L * Q * BW;
    localparam int UW = L * BW;

    logic          in_clock = 1'b0;
    logic          in_reset;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_a;
    logic [SW-1:0] in_b;
    logic [RW-1:0] in_r;
    logic          in_r_valid;
    logic          out_r_take;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_c;

    int checks = 0;
    int errors = 0;
    int taken_count;
    int lat;

    logic [SW-1:0] exp_q[$];
    logic [UW-1:0] exp_u[$];
    logic [SW-1:0] last_c;
    logic [UW-1:0] u;
    logic          mv1;
    logic          mv2;
    logic          exp_adv1;
    logic          exp_adv2;
    logic          exp_accept;

    masked_hpc2_mul_pipe #(
        .NUM_SHARES (D),
        .BIT_WIDTH  (BW),
        .NUM_LANES  (L)
    ) dut (
        .in_clock   (in_clock),
        .in_reset   (in_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_r       (in_r),
        .in_r_valid (in_r_valid),
        .out_r_take (out_r_take),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c)
    );

    always #5 in_clock = ~in_clock;

    // GF(4) multiply with x^2 = x + 1.
    function automatic logic [1:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic p0, p1, p2;
        p0 = x[0] & y[0];
        p1 = (x[0] & y[1]) ^ (x[1] & y[0]);
        p2 = x[1] & y[1];
        return {p1 ^ p2, p0 ^ p2};
    endfunction

    function automatic int pairIdx(input int i, input int j);
        int lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * D - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    function automatic logic [SW-1:0] modelShares(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                                  input logic [RW-1:0] r);
        logic [SW-1:0] c;
        logic [1:0] ai, bj, rr, acc;
        c = '0;
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < D; i++) begin
                ai  = a[(l*D+i)*BW +: BW];
                acc = mul2(ai, b[(l*D+i)*BW +: BW]);
                for (int j = 0; j < D; j++) begin
                    if (j != i) begin
                        bj  = b[(l*D+j)*BW +: BW];
                        rr  = r[(l*Q+pairIdx(i, j))*BW +: BW];
                        acc = acc ^ mul2(ai, bj ^ rr) ^ mul2(~ai, rr);
                    end
                end
                c[(l*D+i)*BW +: BW] = acc;
            end
        end
        return c;
    endfunction

    function automatic logic [UW-1:0] xorShares(input logic [SW-1:0] x);
        logic [UW-1:0] res;
        res = '0;
        for (int l = 0; l < L; l++)
            for (int i = 0; i < D; i++)
                res[l*BW +: BW] = res[l*BW +: BW] ^ x[(l*D+i)*BW +: BW];
        return res;
    endfunction

    function automatic logic [UW-1:0] unmaskedProd(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [UW-1:0] xa, xb, res;
        xa  = xorShares(a);
        xb  = xorShares(b);
        res = '0;
        for (int l = 0; l < L; l++)
            res[l*BW +: BW] = mul2(xa[l*BW +: BW], xb[l*BW +: BW]);
        return res;
    endfunction

    function automatic logic [SW-1:0] rndWord();
        logic [31:0] t;
        t = $urandom;
        return t[SW-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rv, input logic ordy,
                                 input logic [SW-1:0] a, input logic [SW-1:0] b,
                                 input logic [RW-1:0] r);
        in_valid   = v;
        in_r_valid = rv;
        out_ready  = ordy;
        in_a       = a;
        in_b       = b;
        in_r       = r;
    endtask

    task automatic checkOutput();
        exp_adv2   = !mv2 || out_ready;
        exp_adv1   = !mv1 || exp_adv2;
        exp_accept = in_valid && in_r_valid && exp_adv1;
        check("in_ready", 64'(in_ready), 64'(exp_adv1));
        check("r_take", 64'(out_r_take), 64'(exp_accept));
        check("out_valid", 64'(out_valid), 64'(mv2));
        if (mv2) begin
            check("out_c_shares", 64'(out_c), 64'(exp_q[0]));
            check("out_c_unmasked", 64'(xorShares(out_c)), 64'(exp_u[0]));
            if (out_ready) begin
                last_c = exp_q.pop_front();
                void'(exp_u.pop_front());
            end
        end else begin
            check("out_c_hold", 64'(out_c), 64'(last_c));
        end
        if (exp_accept) begin
            exp_q.push_back(modelShares(in_a, in_b, in_r));
            exp_u.push_back(unmaskedProd(in_a, in_b));
        end
    endtask

    task automatic cycle();
        #1;
        checkOutput();
        if (out_r_take) taken_count++;
        @(posedge in_clock);
        if (exp_adv2) mv2 = mv1;
        if (exp_adv1) mv1 = exp_accept;
        @(negedge in_clock);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, rndWord(), rndWord(), rndWord());
            cycle();
        end
    endtask

    task automatic resetModel();
        exp_q.delete();
        exp_u.delete();
        mv1    = 1'b0;
        mv2    = 1'b0;
        last_c = '0;
    endtask

    initial begin
        resetModel();
        taken_count = 0;
        in_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0);
        @(negedge in_clock);
        @(negedge in_clock);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_c", 64'(out_c), 64'd0);
        in_reset = 1'b0;
        idleCycles(1);

        // Directed lane-0 product 1*1, then 0*1; other lanes zero.
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000001, 24'h000004, 24'h000001);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0);
        lat = 1;
        while (!out_valid && lat < 8) begin
            cycle();
            lat++;
        end
        check("latency", 64'(lat), 64'(MUL_PIPE_LATENCY));
        u = xorShares(out_c);
        check("basic_unmasked_one", 64'(u[1:0]), 64'd1);
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000005, 24'h000004, 24'h000002);
        cycle();
        idleCycles(1);
        u = xorShares(out_c);
        check("basic_unmasked_zero", 64'(u[1:0]), 64'd0);
        idleCycles(2);

        $display("[TB] streaming 100 transactions");
        for (int n = 0; n < 100; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, rndWord(), rndWord(), rndWord());
            cycle();
        end
        idleCycles(3);

        $display("[TB] backpressure");
        taken_count = 0;
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, rndWord(), rndWord(), rndWord());
            cycle();
        end
        check("bp_accepts", 64'(taken_count), 64'd2);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, rndWord(), rndWord(), rndWord());
            cycle();
        end
        idleCycles(4);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] randomness starvation");
        taken_count = 0;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, rndWord(), rndWord(), rndWord());
            cycle();
        end
        check("starve_no_take", 64'(taken_count), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, rndWord(), rndWord(), rndWord());
        cycle();
        check("starve_take", 64'(taken_count), 64'd1);

        $display("[TB] bubble hold");
        idleCycles(10);

        $display("[TB] async reset with both stages full");
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, rndWord(), rndWord(), rndWord());
            cycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check("full_before_reset", 64'(out_valid), 64'd1);
        #2;
        in_reset = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_c", 64'(out_c), 64'd0);
        resetModel();
        @(negedge in_clock);
        in_reset = 1'b0;
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b1, rndWord(), rndWord(), rndWord());
        cycle();
        idleCycles(4);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
